// File: rtl/fetch_pkg.sv
// Shared types and default parameter values for the pipelined fetch unit.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_BOOT,
    S_FETCH,
    S_REDIR
  } state_e;

  typedef enum logic [1:0] {
    R_NONE,
    R_BRANCH,
    R_JUMP,
    R_JREG
  } redir_e;

  localparam int unsigned DEF_ADDR_W      = 30;
  localparam int unsigned DEF_DATA_W      = 32;
  localparam int unsigned DEF_IMM_W       = 16;
  localparam int unsigned DEF_TARGET_W    = 26;
  localparam int unsigned DEF_QUEUE_DEPTH = 2;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO holding fetched {instruction, pc} entries between the
// instruction memory and decode. Push and pop may coincide at any occupancy.
module fetch_queue #(
  parameter int unsigned WIDTH = 62,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  input  logic             clear_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             full;
  logic             empty;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop_i && !empty;
  assign do_push = push_i && (!full || do_pop);

  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: the storage array is deliberately left without reset; the count
  // already marks every slot invalid, and unreset RAM maps to cheaper cells.
  always_ff @(posedge clk) begin
    if (do_push && !clear_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/pipelined_fetch_unit.sv
// Pipelined instruction fetch: issues word-addressed reads to a 1-cycle
// synchronous memory, queues responses for decode, and redirects on control flow.
module pipelined_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W      = DEF_ADDR_W,
  parameter int unsigned       DATA_W      = DEF_DATA_W,
  parameter int unsigned       IMM_W       = DEF_IMM_W,
  parameter int unsigned       TARGET_W    = DEF_TARGET_W,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter int unsigned       QUEUE_DEPTH = DEF_QUEUE_DEPTH
) (
  input  logic                clk,
  input  logic                reset,
  output logic                imem_req,
  output logic [ADDR_W+1:0]   imem_addr,
  input  logic [DATA_W-1:0]   imem_rdata,
  input  logic [ADDR_W-1:0]   ctrl_pc,
  input  logic                branch,
  input  logic                LTZ,
  input  logic                jump,
  input  logic                jumpReg,
  input  logic [IMM_W-1:0]    imm16,
  input  logic [TARGET_W-1:0] target,
  input  logic [DATA_W-1:0]   regData,
  output logic                inst_valid,
  input  logic                inst_ready,
  output logic [DATA_W-1:0]   instruction,
  output logic [ADDR_W-1:0]   inst_pc
);

  localparam int unsigned CNT_W   = $clog2(QUEUE_DEPTH + 1);
  localparam int unsigned ENTRY_W = DATA_W + ADDR_W;

  state_e              state_q;
  logic [ADDR_W-1:0]   pc_q;
  logic [ADDR_W-1:0]   pc_d;
  logic [ADDR_W-1:0]   req_pc_q;
  logic                epoch_q;
  logic                tag_q;
  logic                outstanding_q;

  redir_e              redir_kind;
  logic [ADDR_W-1:0]   redir_target;
  logic [ADDR_W-1:0]   imm_sext;
  logic                redir;
  logic                issue;
  logic                push;
  logic                pop;
  logic [CNT_W:0]      occ;
  logic [CNT_W-1:0]    q_count;
  logic [ENTRY_W-1:0]  q_head;
  logic                unused_regdata;

  assign imm_sext = {{(ADDR_W - IMM_W){imm16[IMM_W-1]}}, imm16};

  // NOTE: every always_comb output gets a default first, so no path through
  // the block can leave it unassigned and infer a latch.
  always_comb begin
    redir_kind   = R_NONE;
    redir_target = pc_q;
    if (jumpReg) begin
      redir_kind   = R_JREG;
      redir_target = regData[ADDR_W+1:2];
    end else if (jump) begin
      redir_kind   = R_JUMP;
      redir_target = {ctrl_pc[ADDR_W-1:TARGET_W], target};
    end else if (branch && LTZ) begin
      redir_kind   = R_BRANCH;
      redir_target = ctrl_pc + ADDR_W'(1) + imm_sext;
    end
  end

  assign redir = (redir_kind != R_NONE);

  assign inst_valid = (q_count != '0) && !redir;
  assign pop        = inst_valid && inst_ready;

  // Slots already promised: queued entries plus the response still in flight.
  assign occ   = (CNT_W+1)'(q_count) + (CNT_W+1)'(outstanding_q) - (CNT_W+1)'(pop);
  assign issue = (state_q != S_BOOT) && !redir && (occ < (CNT_W+1)'(QUEUE_DEPTH));

  assign imem_req  = issue;
  assign imem_addr = {pc_q, 2'b00};

  // A response from before the latest redirect carries the old epoch and is dropped.
  assign push = outstanding_q && (tag_q == epoch_q) && !redir;

  always_comb begin
    pc_d = pc_q;
    if (redir)      pc_d = redir_target;
    else if (issue) pc_d = pc_q + ADDR_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_BOOT;
      pc_q          <= RESET_PC;
      req_pc_q      <= RESET_PC;
      epoch_q       <= 1'b0;
      tag_q         <= 1'b0;
      outstanding_q <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      outstanding_q <= issue;
      if (issue) begin
        tag_q    <= epoch_q;
        req_pc_q <= pc_q;
      end
      if (redir) begin
        epoch_q <= ~epoch_q;
        state_q <= S_REDIR;
      end else begin
        unique case (state_q)
          S_BOOT:  state_q <= S_FETCH;
          S_FETCH: state_q <= S_FETCH;
          S_REDIR: state_q <= S_FETCH;
          default: state_q <= S_BOOT;
        endcase
      end
    end
  end

  fetch_queue #(
    .WIDTH (ENTRY_W),
    .DEPTH (QUEUE_DEPTH),
    .CNT_W (CNT_W)
  ) u_queue (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .wdata_i ({imem_rdata, req_pc_q}),
    .pop_i   (pop),
    .clear_i (redir),
    .rdata_o (q_head),
    .count_o (q_count)
  );

  assign instruction = q_head[ENTRY_W-1:ADDR_W];
  assign inst_pc     = q_head[ADDR_W-1:0];

  assign unused_regdata = ^{regData[1:0], regData >> (ADDR_W + 2)};

endmodule

// File: tb/tb_pipelined_fetch_unit.sv
// Bench for pipelined_fetch_unit: a stream-level model checked every cycle,
// plus directed redirect, stall, wrap and reset scenarios with literal expectations.
module tb_pipelined_fetch_unit;

  localparam int unsigned       ADDR_W   = 30;
  localparam int unsigned       DATA_W   = 32;
  localparam int unsigned       IMM_W    = 16;
  localparam int unsigned       TARGET_W = 26;
  localparam int unsigned       DEPTH    = 2;
  localparam logic [ADDR_W-1:0] RESET_PC = '0;

  logic                clk;
  logic                reset;
  logic                imem_req;
  logic [ADDR_W+1:0]   imem_addr;
  logic [DATA_W-1:0]   imem_rdata;
  logic [ADDR_W-1:0]   ctrl_pc;
  logic                branch;
  logic                LTZ;
  logic                jump;
  logic                jumpReg;
  logic [IMM_W-1:0]    imm16;
  logic [TARGET_W-1:0] target;
  logic [DATA_W-1:0]   regData;
  logic                inst_valid;
  logic                inst_ready;
  logic [DATA_W-1:0]   instruction;
  logic [ADDR_W-1:0]   inst_pc;

  int total = 0;
  int bad   = 0;

  pipelined_fetch_unit #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .IMM_W       (IMM_W),
    .TARGET_W    (TARGET_W),
    .RESET_PC    (RESET_PC),
    .QUEUE_DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .ctrl_pc     (ctrl_pc),
    .branch      (branch),
    .LTZ         (LTZ),
    .jump        (jump),
    .jumpReg     (jumpReg),
    .imm16       (imm16),
    .target      (target),
    .regData     (regData),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .instruction (instruction),
    .inst_pc     (inst_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory word n holds n.
  function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    return DATA_W'(a);
  endfunction

  always @(posedge clk) begin
    if (imem_req) imem_rdata <= mem_word(imem_addr[ADDR_W+1:2]);
    else          imem_rdata <= 32'hDEAD_BEEF;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Redirect target computed from the control-flow rules with plain arithmetic.
  function automatic logic [ADDR_W-1:0] model_target(
    input logic br, input logic ltz, input logic j, input logic jr,
    input logic [ADDR_W-1:0] cpc, input logic [IMM_W-1:0] imm,
    input logic [TARGET_W-1:0] tg, input logic [DATA_W-1:0] rd);
    longint off;
    off = longint'($signed(imm));
    if (jr) return ADDR_W'(rd / 4);
    if (j)  return ((cpc >> TARGET_W) << TARGET_W) | ADDR_W'(tg);
    if (br && ltz) return ADDR_W'(longint'(cpc) + 1 + off);
    return '0;
  endfunction

  // Stream model: owed = fetched but not yet delivered, avail = responses
  // already landed in the queue, pend = response arriving next cycle.
  logic [ADDR_W-1:0] m_dpc = RESET_PC;
  logic [ADDR_W-1:0] m_fpc = RESET_PC;
  int                m_owed = 0;
  int                m_avail = 0;
  int                m_pend = 0;
  bit                m_boot = 1'b1;

  always @(negedge clk) begin
    bit               m_redir;
    bit               m_valid;
    bit               m_pop;
    bit               m_req;
    logic [ADDR_W-1:0] m_tgt;
    if (reset) begin
      check("reset_valid", inst_valid, 0);
      check("reset_req", imem_req, 0);
      m_boot = 1'b1; m_owed = 0; m_avail = 0; m_pend = 0;
      m_dpc = RESET_PC; m_fpc = RESET_PC;
    end else begin
      m_redir = jumpReg || jump || (branch && LTZ);
      m_tgt   = model_target(branch, LTZ, jump, jumpReg, ctrl_pc, imm16, target, regData);
      m_valid = !m_boot && (m_avail > 0) && !m_redir;
      m_pop   = m_valid && inst_ready;
      m_req   = !m_boot && !m_redir && (m_owed - int'(m_pop) < int'(DEPTH));
      check("model_valid", inst_valid, m_valid);
      check("model_req", imem_req, m_req);
      if (m_valid) begin
        check("model_pc", inst_pc, m_dpc);
        check("model_instr", instruction, mem_word(m_dpc));
      end
      if (m_req) check("model_addr", imem_addr, {m_fpc, 2'b00});
      if (m_boot) begin
        m_boot = 1'b0;
      end else if (m_redir) begin
        m_dpc = m_tgt; m_fpc = m_tgt; m_owed = 0; m_avail = 0; m_pend = 0;
      end else begin
        if (m_pop) begin
          m_dpc = m_dpc + 1'b1; m_owed--; m_avail--;
        end
        m_avail += m_pend;
        m_pend = int'(m_req);
        if (m_req) begin
          m_fpc = m_fpc + 1'b1; m_owed++;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pop(output logic [ADDR_W-1:0] p);
    bit got;
    got = 1'b0;
    p = '0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (inst_valid && inst_ready) begin
        p = inst_pc;
        got = 1'b1;
      end
    end
    if (!got) check("pop_timeout", 0, 1);
  endtask

  task automatic do_redir(input logic br, input logic ltz, input logic j, input logic jr,
                          input logic [ADDR_W-1:0] cpc, input logic [IMM_W-1:0] imm,
                          input logic [TARGET_W-1:0] tg, input logic [DATA_W-1:0] rd);
    cyc();
    branch = br; LTZ = ltz; jump = j; jumpReg = jr;
    ctrl_pc = cpc; imm16 = imm; target = tg; regData = rd;
    cyc();
    branch = 1'b0; LTZ = 1'b0; jump = 1'b0; jumpReg = 1'b0;
  endtask

  initial begin
    logic [ADDR_W-1:0] p;
    bit                found;
    reset = 1'b1; inst_ready = 1'b1;
    branch = 1'b0; LTZ = 1'b0; jump = 1'b0; jumpReg = 1'b0;
    ctrl_pc = '0; imm16 = '0; target = '0; regData = '0;

    repeat (3) cyc();
    check("rst_valid", inst_valid, 0);
    check("rst_req", imem_req, 0);
    reset = 1'b0;

    // First instruction three cycles after release, then one per cycle.
    repeat (3) begin
      @(negedge clk);
      check("boot_latency_low", inst_valid, 0);
    end
    @(negedge clk);
    check("first_valid", inst_valid, 1);
    check("first_pc", inst_pc, 0);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      check("seq_valid", inst_valid, 1);
      check("seq_pc", inst_pc, i);
    end

    // Stall with pc 4 at the head.
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cyc();
      if (inst_valid && inst_pc == 4) found = 1'b1;
    end
    check("stall_found_pc4", found, 1);
    inst_ready = 1'b0;
    repeat (5) cyc();
    check("stall_req_low", imem_req, 0);
    check("stall_head", inst_pc, 4);
    inst_ready = 1'b1;
    for (int i = 4; i <= 6; i++) begin
      @(negedge clk);
      check("after_stall_pc", inst_pc, i);
    end

    // Taken branch, not-taken branch, backward branch.
    do_redir(1, 1, 0, 0, 30'd7, 16'd5, '0, '0);
    wait_pop(p);
    check("branch_fwd", p, 13);
    do_redir(1, 0, 0, 0, 30'd7, 16'd5, '0, '0);
    wait_pop(p);
    do_redir(1, 1, 0, 0, 30'd10, 16'hFFFC, '0, '0);
    wait_pop(p);
    check("branch_back", p, 7);

    // Jump, then jump and jumpReg together.
    do_redir(0, 0, 1, 0, 30'h2000_0005, '0, 26'd3, '0);
    wait_pop(p);
    check("jump", p, 30'h2000_0003);
    do_redir(0, 0, 1, 1, 30'h2000_0005, '0, 26'd3, 32'h40);
    wait_pop(p);
    check("jreg_wins", p, 16);

    // Fill the queue, release one pop, redirect while a response is in flight.
    cyc();
    inst_ready = 1'b0;
    repeat (4) cyc();
    check("full_req_low", imem_req, 0);
    inst_ready = 1'b1;
    cyc();
    jump = 1'b1; ctrl_pc = '0; target = 26'd100;
    @(negedge clk);
    check("redir_valid_forced", inst_valid, 0);
    check("redir_req_low", imem_req, 0);
    cyc();
    jump = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("redir_latency_low", inst_valid, 0);
    end
    @(negedge clk);
    check("redir_first_valid", inst_valid, 1);
    check("redir_first_pc", inst_pc, 100);

    // Wrap of the word PC.
    do_redir(0, 0, 0, 1, '0, '0, '0, 32'hFFFF_FFF8);
    wait_pop(p);
    check("wrap_pc0", p, 30'h3FFF_FFFE);
    @(negedge clk);
    check("wrap_pc1", inst_pc, 30'h3FFF_FFFF);
    check("wrap_instr1", instruction, 32'h3FFF_FFFF);
    @(negedge clk);
    check("wrap_pc2", inst_pc, 0);
    @(negedge clk);
    check("wrap_pc3", inst_pc, 1);

    // Reset mid-stream.
    cyc();
    reset = 1'b1;
    #1;
    check("midrst_valid", inst_valid, 0);
    check("midrst_req", imem_req, 0);
    repeat (2) cyc();
    reset = 1'b0;
    wait_pop(p);
    check("restart_pc", p, RESET_PC);
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
